// File: rtl/uadd_5_arb_if.sv
// Handshake bundle between two operand requesters, the shared adder stage and
// the result consumer. The master side drives the requests and res_ready.
// The slave side is the arbiter.
interface uadd_5_arb_if #(
    parameter int WIDTH = 5
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_s;
    logic             res_of;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_id, res_s, res_of,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_id, res_s, res_of,
        input  res_ready
    );
endinterface

// File: rtl/uadd_5_arb.sv
// Two-requester round-robin arbiter in front of one shared saturating adder.
// The adder result is registered with the tag of its requester. A saturating
// counter tracks how many accepted additions overflowed.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | result register free, res_valid = 0
// FULL  | result register holds an unconsumed result
module uadd_5_arb #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    uadd_5_arb_if.slave      bus,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic             sum_of;
    logic             res_id_q;
    logic [WIDTH-1:0] res_s_q;
    logic             res_of_q;

    // Grant selection and acceptance. Reset blocks acceptance so that a
    // request presented while rst is high is never acknowledged.
    always_comb begin
        can_accept = (state == EMPTY) | bus.res_ready;
        grant0     = bus.req0_valid & (~bus.req1_valid | ~prio);
        grant1     = bus.req1_valid & (~bus.req0_valid |  prio);
        accept     = (grant0 | grant1) & can_accept & ~rst;
    end

    assign bus.req0_ready = grant0 & can_accept & ~rst;
    assign bus.req1_ready = grant1 & can_accept & ~rst;

    // Operand mux and saturating add on the granted pair.
    always_comb begin
        op_a   = grant1 ? bus.req1_a : bus.req0_a;
        op_b   = grant1 ? bus.req1_b : bus.req0_b;
        sum    = {1'b0, op_a} + {1'b0, op_b};
        sum_of = sum[WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a new acceptance always fills the register, even when the
    // old result is drained in the same cycle.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if ((state == FULL) && bus.res_ready) begin
            state_nxt = EMPTY;
        end
    end

    // Result registers and round-robin pointer; the pointer moves to the
    // requester that lost, so the winner cannot be granted twice in a row
    // while the other keeps asking.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_id_q <= 1'b0;
            res_s_q  <= '0;
            res_of_q <= 1'b0;
            prio     <= 1'b0;
        end else if (accept) begin
            res_id_q <= grant1;
            res_s_q  <= sum_of ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            res_of_q <= sum_of;
            prio     <= ~grant1;
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_id    = res_id_q;
    assign bus.res_s     = res_s_q;
    assign bus.res_of    = res_of_q;

    // Overflow event counter; clear wins over increment, sticks at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (accept && sum_of && (ovf_cnt != {CNT_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uadd_5_arb.sv
// Bench for uadd_5_arb: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_uadd_5_arb;

    localparam int WIDTH = 5;
    localparam int CNT_W = 8;
    localparam int SMAX  = (1 << WIDTH) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ovf_clr = 1'b0;
    logic [CNT_W-1:0] ovf_cnt;

    uadd_5_arb_if #(.WIDTH(WIDTH)) intf ();

    uadd_5_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (intf),
        .ovf_clr (ovf_clr),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model of the visible result stage.
    bit m_full = 1'b0;
    int m_prio = 0;
    int m_id   = 0;
    int m_s    = 0;
    int m_of   = 0;
    int m_cnt  = 0;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d", name, act, act, exp);
        end
    endtask

    // Which requester the model grants this cycle, -1 if nobody asks.
    function automatic int model_grant();
        if (intf.req0_valid && intf.req1_valid) return m_prio;
        if (intf.req0_valid) return 0;
        if (intf.req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit model_room();
        return !rst && (!m_full || intf.res_ready);
    endfunction

    // Model advance at each rising edge, using the inputs held since the
    // previous drive.
    always @(posedge clk) begin
        int g;
        int a;
        int b;
        int total;
        bit acc;
        if (rst) begin
            m_full = 1'b0; m_prio = 0; m_id = 0; m_s = 0; m_of = 0; m_cnt = 0;
        end else begin
            g   = model_grant();
            acc = (g >= 0) && model_room();
            a   = (g == 1) ? int'(intf.req1_a) : int'(intf.req0_a);
            b   = (g == 1) ? int'(intf.req1_b) : int'(intf.req0_b);
            total = a + b;
            if (ovf_clr) m_cnt = 0;
            else if (acc && total > SMAX && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (acc) begin
                m_full = 1'b1;
                m_id   = g;
                m_s    = (total > SMAX) ? SMAX : total;
                m_of   = (total > SMAX) ? 1 : 0;
                m_prio = 1 - g;
            end else if (m_full && intf.res_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        int g;
        if (chk_en) begin
            g = model_grant();
            expect_eq("res_valid",  intf.res_valid,  m_full);
            expect_eq("res_id",     intf.res_id,     m_id);
            expect_eq("res_s",      intf.res_s,      m_s);
            expect_eq("res_of",     intf.res_of,     m_of);
            expect_eq("ovf_cnt",    ovf_cnt,         m_cnt);
            expect_eq("req0_ready", intf.req0_ready, (g == 0) && model_room());
            expect_eq("req1_ready", intf.req1_ready, (g == 1) && model_room());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input bit rr);
        intf.req0_valid = v0;
        intf.req0_a     = a0[WIDTH-1:0];
        intf.req0_b     = b0[WIDTH-1:0];
        intf.req1_valid = v1;
        intf.req1_a     = a1[WIDTH-1:0];
        intf.req1_b     = b1[WIDTH-1:0];
        intf.res_ready  = rr;
    endtask

    initial begin
        logic [WIDTH-1:0] held_s;
        logic             held_id;
        logic             held_of;

        drive(1, 1, 1, 1, 2, 2, 1);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        #1;
        expect_eq("rst req0_ready", intf.req0_ready, 0);
        expect_eq("rst req1_ready", intf.req1_ready, 0);
        tick();
        expect_eq("rst res_valid", intf.res_valid, 0);
        expect_eq("rst ovf_cnt", ovf_cnt, 0);

        // Single request.
        rst = 1'b0;
        drive(1, 10, 12, 0, 0, 0, 1);
        #1;
        expect_eq("single req0_ready", intf.req0_ready, 1);
        tick();
        expect_eq("single res_valid", intf.res_valid, 1);
        expect_eq("single res_s", intf.res_s, 22);
        expect_eq("single res_of", intf.res_of, 0);
        expect_eq("single res_id", intf.res_id, 0);

        // Saturation, then the exact-max boundary.
        drive(0, 0, 0, 1, 20, 15, 1);
        tick();
        expect_eq("sat res_s", intf.res_s, 31);
        expect_eq("sat res_of", intf.res_of, 1);
        expect_eq("sat res_id", intf.res_id, 1);
        expect_eq("sat ovf_cnt", ovf_cnt, 1);
        drive(0, 0, 0, 1, 16, 15, 1);
        tick();
        expect_eq("edge res_s", intf.res_s, 31);
        expect_eq("edge res_of", intf.res_of, 0);
        expect_eq("edge ovf_cnt", ovf_cnt, 1);

        // Round-robin after reset with both requesters always asking.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 1, 2, 1, 3, 4, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_eq("rr res_valid", intf.res_valid, 1);
            expect_eq("rr res_id", intf.res_id, i % 2);
            expect_eq("rr res_s", intf.res_s, (i % 2) ? 7 : 3);
        end

        // Backpressure: hold for three cycles, then drain and refill.
        drive(1, 3, 4, 1, 9, 9, 0);
        held_s  = intf.res_s;
        held_id = intf.res_id;
        held_of = intf.res_of;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_eq("bp res_s", intf.res_s, held_s);
            expect_eq("bp res_id", intf.res_id, held_id);
            expect_eq("bp res_of", intf.res_of, held_of);
            expect_eq("bp req0_ready", intf.req0_ready, 0);
            expect_eq("bp req1_ready", intf.req1_ready, 0);
        end
        intf.res_ready = 1'b1;
        #1;
        expect_eq("bp release req0_ready", intf.req0_ready, 1);
        tick();
        expect_eq("bp new res_id", intf.res_id, 0);
        expect_eq("bp new res_s", intf.res_s, 7);
        expect_eq("bp res_valid", intf.res_valid, 1);

        // Counter saturation and clear-over-increment.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 31, 31, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) tick();
        expect_eq("cnt saturate", ovf_cnt, 255);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        expect_eq("cnt clear", ovf_cnt, 0);
        expect_eq("cnt clear res_of", intf.res_of, 1);

        // Reset while holding a result from requester 1.
        drive(0, 0, 0, 1, 30, 30, 1);
        tick();
        expect_eq("mid res_id", intf.res_id, 1);
        expect_eq("mid ovf_cnt", ovf_cnt, 1);
        drive(1, 5, 5, 1, 6, 6, 0);
        rst = 1'b1;
        #1;
        expect_eq("mid rst req0_ready", intf.req0_ready, 0);
        expect_eq("mid rst req1_ready", intf.req1_ready, 0);
        tick();
        rst = 1'b0;
        expect_eq("mid res_valid", intf.res_valid, 0);
        expect_eq("mid res_s", intf.res_s, 0);
        expect_eq("mid ovf_cnt0", ovf_cnt, 0);
        intf.res_ready = 1'b1;
        tick();
        expect_eq("mid first grant", intf.res_id, 0);
        expect_eq("mid first res_s", intf.res_s, 10);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, SMAX), $urandom_range(0, SMAX),
                  $urandom_range(0, 3) != 0, $urandom_range(0, SMAX), $urandom_range(0, SMAX),
                  $urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        ovf_clr = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
